// File: rtl/mul_seq_decoder.sv
// Receive-side decoder for the 4-beat multiply-sequence stream (d, d*3, d*7, d*8).
// Optional error counter output err_cnt is enabled by defining MUL_SEQ_DEC_ERRCNT_EN.
module mul_seq_decoder #(
    parameter int DW = 8,
    parameter int OW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_grant,
    input  logic [OW-1:0] in_data,
    output logic          dec_valid,
    output logic [DW-1:0] dec_data,
    output logic [3:0]    dec_err,
    output logic          frame_abort,
    output logic          busy
`ifdef MUL_SEQ_DEC_ERRCNT_EN
    ,
    output logic [15:0]   err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, B1, B2, B3} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_dcap;
    logic [3:0]    r_err;
    logic          r_dec_valid;
    logic [DW-1:0] r_dec_data;
    logic [3:0]    r_dec_err;
    logic          r_frame_abort;
    logic          r_busy;

    logic          w_load;
    logic          w_abort;
    logic          w_done;
    logic [3:0]    w_mis_vec;
    logic [3:0]    w_err_fin;
    logic [OW-1:0] w_d_ext;
    logic [OW-1:0] w_exp1;
    logic [OW-1:0] w_exp2;
    logic [OW-1:0] w_exp3;

    // OW = DW+3, so every expected product fits without truncation.
    assign w_d_ext = OW'(r_dcap);
    assign w_exp1  = w_d_ext * OW'(3);
    assign w_exp2  = w_d_ext * OW'(7);
    assign w_exp3  = {r_dcap, 3'b000};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_abort     = 1'b0;
        w_done      = 1'b0;
        w_mis_vec   = '0;
        case (r_state)
            IDLE: begin
                if (in_grant) begin
                    w_load      = 1'b1;
                    w_state_nxt = B1;
                end
            end
            B1: begin
                if (in_grant) begin
                    w_abort     = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = B1;
                end else begin
                    w_mis_vec[1] = (in_data != w_exp1);
                    w_state_nxt  = B2;
                end
            end
            B2: begin
                if (in_grant) begin
                    w_abort     = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = B1;
                end else begin
                    w_mis_vec[2] = (in_data != w_exp2);
                    w_state_nxt  = B3;
                end
            end
            B3: begin
                if (in_grant) begin
                    w_abort     = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = B1;
                end else begin
                    w_mis_vec[3] = (in_data != w_exp3);
                    w_done       = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Final error vector includes the beat-3 result decided on the same edge.
    assign w_err_fin = r_err | w_mis_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dcap        <= '0;
            r_err         <= '0;
            r_dec_valid   <= 1'b0;
            r_dec_data    <= '0;
            r_dec_err     <= '0;
            r_frame_abort <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_dec_valid   <= w_done;
            r_frame_abort <= w_abort;
            r_busy        <= (w_state_nxt != IDLE);
            if (w_load) begin
                r_dcap <= in_data[DW-1:0];
                r_err  <= {3'b000, |in_data[OW-1:DW]};
            end else begin
                r_err  <= w_err_fin;
            end
            if (w_done) begin
                r_dec_data <= r_dcap;
                r_dec_err  <= w_err_fin;
            end
        end
    end

    assign dec_valid   = r_dec_valid;
    assign dec_data    = r_dec_data;
    assign dec_err     = r_dec_err;
    assign frame_abort = r_frame_abort;
    assign busy        = r_busy;

`ifdef MUL_SEQ_DEC_ERRCNT_EN
    logic [15:0] r_err_cnt;
    logic        w_cnt_inc;

    assign w_cnt_inc = (w_done && (|w_err_fin)) || w_abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt <= '0;
        end else if (w_cnt_inc && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_mul_seq_decoder.sv
// Self-checking bench for mul_seq_decoder: directed vector table, hand-written
// reset/abort sequences and randomized traffic against a frame-level model.
module tb_mul_seq_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_grant;
    logic [10:0] in_data;
    logic        dec_valid;
    logic [7:0]  dec_data;
    logic [3:0]  dec_err;
    logic        frame_abort;
    logic        busy;
`ifdef MUL_SEQ_DEC_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    always #5 clk = ~clk;

    mul_seq_decoder #(.DW(8), .OW(11)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_grant    (in_grant),
        .in_data     (in_data),
        .dec_valid   (dec_valid),
        .dec_data    (dec_data),
        .dec_err     (dec_err),
        .frame_abort (frame_abort),
        .busy        (busy)
`ifdef MUL_SEQ_DEC_ERRCNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level reference model: collects the words of the current frame.
    logic [10:0] q[$];
    logic        m_valid;
    logic        m_abort;
    logic [7:0]  m_data;
    logic [3:0]  m_err;
    logic        m_busy;
    int          m_cnt;

    task automatic model_reset();
        q.delete();
        m_valid = 0; m_abort = 0; m_data = 0; m_err = 0; m_busy = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic g, input logic [10:0] d);
        int dv;
        m_valid = 0;
        m_abort = 0;
        if (g) begin
            if (q.size() != 0) m_abort = 1;
            q.delete();
            q.push_back(d);
        end else if (q.size() != 0) begin
            q.push_back(d);
            if (q.size() == 4) begin
                dv       = int'(q[0]) % 256;
                m_valid  = 1;
                m_data   = 8'(dv);
                m_err[0] = (int'(q[0]) / 256) != 0;
                m_err[1] = int'(q[1]) != dv * 3;
                m_err[2] = int'(q[2]) != dv * 7;
                m_err[3] = int'(q[3]) != dv * 8;
                q.delete();
            end
        end
        m_busy = (q.size() != 0);
        if (((m_valid && m_err != 0) || m_abort) && m_cnt < 65535) m_cnt++;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("dec_valid", {15'b0, dec_valid}, {15'b0, m_valid});
        chk("frame_abort", {15'b0, frame_abort}, {15'b0, m_abort});
        chk("dec_data", {8'b0, dec_data}, {8'b0, m_data});
        chk("dec_err", {12'b0, dec_err}, {12'b0, m_err});
        chk("busy", {15'b0, busy}, {15'b0, m_busy});
        chk("pulse_excl", {15'b0, dec_valid & frame_abort}, 16'h0);
`ifdef MUL_SEQ_DEC_ERRCNT_EN
        chk("err_cnt", err_cnt, 16'(m_cnt));
`endif
    endtask

    task automatic step(input logic g, input logic [10:0] d);
        in_grant = g;
        in_data  = d;
        @(posedge clk);
        model_edge(g, d);
        #1;
    endtask

    typedef struct {
        logic        g;
        logic [10:0] d;
        logic        v;
        logic        a;
        logic [7:0]  dd;
        logic [3:0]  e;
        logic        b;
    } vec_t;

    vec_t tbl[39];

    initial begin
        tbl[0]  = '{1'b1, 11'd5,    1'b0, 1'b0, 8'd0,   4'b0000, 1'b1};
        tbl[1]  = '{1'b0, 11'd15,   1'b0, 1'b0, 8'd0,   4'b0000, 1'b1};
        tbl[2]  = '{1'b0, 11'd35,   1'b0, 1'b0, 8'd0,   4'b0000, 1'b1};
        tbl[3]  = '{1'b0, 11'd40,   1'b1, 1'b0, 8'd5,   4'b0000, 1'b0};
        tbl[4]  = '{1'b0, 11'd0,    1'b0, 1'b0, 8'd5,   4'b0000, 1'b0};
        tbl[5]  = '{1'b1, 11'd255,  1'b0, 1'b0, 8'd5,   4'b0000, 1'b1};
        tbl[6]  = '{1'b0, 11'd765,  1'b0, 1'b0, 8'd5,   4'b0000, 1'b1};
        tbl[7]  = '{1'b0, 11'd1785, 1'b0, 1'b0, 8'd5,   4'b0000, 1'b1};
        tbl[8]  = '{1'b0, 11'd2040, 1'b1, 1'b0, 8'd255, 4'b0000, 1'b0};
        tbl[9]  = '{1'b1, 11'd0,    1'b0, 1'b0, 8'd255, 4'b0000, 1'b1};
        tbl[10] = '{1'b0, 11'd0,    1'b0, 1'b0, 8'd255, 4'b0000, 1'b1};
        tbl[11] = '{1'b0, 11'd0,    1'b0, 1'b0, 8'd255, 4'b0000, 1'b1};
        tbl[12] = '{1'b0, 11'd0,    1'b1, 1'b0, 8'd0,   4'b0000, 1'b0};
        tbl[13] = '{1'b1, 11'd5,    1'b0, 1'b0, 8'd0,   4'b0000, 1'b1};
        tbl[14] = '{1'b0, 11'd15,   1'b0, 1'b0, 8'd0,   4'b0000, 1'b1};
        tbl[15] = '{1'b0, 11'd36,   1'b0, 1'b0, 8'd0,   4'b0000, 1'b1};
        tbl[16] = '{1'b0, 11'd40,   1'b1, 1'b0, 8'd5,   4'b0100, 1'b0};
        tbl[17] = '{1'b1, 11'h105,  1'b0, 1'b0, 8'd5,   4'b0100, 1'b1};
        tbl[18] = '{1'b0, 11'd15,   1'b0, 1'b0, 8'd5,   4'b0100, 1'b1};
        tbl[19] = '{1'b0, 11'd35,   1'b0, 1'b0, 8'd5,   4'b0100, 1'b1};
        tbl[20] = '{1'b0, 11'd40,   1'b1, 1'b0, 8'd5,   4'b0001, 1'b0};
        tbl[21] = '{1'b1, 11'd9,    1'b0, 1'b0, 8'd5,   4'b0001, 1'b1};
        tbl[22] = '{1'b0, 11'd27,   1'b0, 1'b0, 8'd5,   4'b0001, 1'b1};
        tbl[23] = '{1'b1, 11'd4,    1'b0, 1'b1, 8'd5,   4'b0001, 1'b1};
        tbl[24] = '{1'b0, 11'd12,   1'b0, 1'b0, 8'd5,   4'b0001, 1'b1};
        tbl[25] = '{1'b0, 11'd28,   1'b0, 1'b0, 8'd5,   4'b0001, 1'b1};
        tbl[26] = '{1'b0, 11'd32,   1'b1, 1'b0, 8'd4,   4'b0000, 1'b0};
        tbl[27] = '{1'b0, 11'h7FF,  1'b0, 1'b0, 8'd4,   4'b0000, 1'b0};
        tbl[28] = '{1'b1, 11'd1,    1'b0, 1'b0, 8'd4,   4'b0000, 1'b1};
        tbl[29] = '{1'b0, 11'd3,    1'b0, 1'b0, 8'd4,   4'b0000, 1'b1};
        tbl[30] = '{1'b0, 11'd7,    1'b0, 1'b0, 8'd4,   4'b0000, 1'b1};
        tbl[31] = '{1'b1, 11'd2,    1'b0, 1'b1, 8'd4,   4'b0000, 1'b1};
        tbl[32] = '{1'b0, 11'd6,    1'b0, 1'b0, 8'd4,   4'b0000, 1'b1};
        tbl[33] = '{1'b0, 11'd14,   1'b0, 1'b0, 8'd4,   4'b0000, 1'b1};
        tbl[34] = '{1'b0, 11'd16,   1'b1, 1'b0, 8'd2,   4'b0000, 1'b0};
        tbl[35] = '{1'b1, 11'h7FF,  1'b0, 1'b0, 8'd2,   4'b0000, 1'b1};
        tbl[36] = '{1'b0, 11'd0,    1'b0, 1'b0, 8'd2,   4'b0000, 1'b1};
        tbl[37] = '{1'b0, 11'd0,    1'b0, 1'b0, 8'd2,   4'b0000, 1'b1};
        tbl[38] = '{1'b0, 11'd0,    1'b1, 1'b0, 8'd255, 4'b1111, 1'b0};

        rst      = 1'b0;
        in_grant = 1'b0;
        in_data  = '0;
        model_reset();
        #1;
        chk("reset_valid", {15'b0, dec_valid}, 16'h0);
        chk("reset_data", {8'b0, dec_data}, 16'h0);
        chk("reset_err", {12'b0, dec_err}, 16'h0);
        chk("reset_abort", {15'b0, frame_abort}, 16'h0);
        chk("reset_busy", {15'b0, busy}, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 11'h3AB);
        chk_model();

        for (int i = 0; i < 39; i++) begin
            step(tbl[i].g, tbl[i].d);
            chk($sformatf("tbl%0d_valid", i), {15'b0, dec_valid}, {15'b0, tbl[i].v});
            chk($sformatf("tbl%0d_abort", i), {15'b0, frame_abort}, {15'b0, tbl[i].a});
            chk($sformatf("tbl%0d_data", i), {8'b0, dec_data}, {8'b0, tbl[i].dd});
            chk($sformatf("tbl%0d_err", i), {12'b0, dec_err}, {12'b0, tbl[i].e});
            chk($sformatf("tbl%0d_busy", i), {15'b0, busy}, {15'b0, tbl[i].b});
`ifdef MUL_SEQ_DEC_ERRCNT_EN
            chk($sformatf("tbl%0d_cnt", i), err_cnt, 16'(m_cnt));
`endif
        end

        // Asynchronous reset in the middle of beat 2 of frame 7.
        step(1'b1, 11'd7);
        chk_model();
        step(1'b0, 11'd21);
        chk_model();
        in_data = 11'd49;
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk_model();
        chk("rst_mid_busy", {15'b0, busy}, 16'h0);
        #2;
        rst = 1'b1;
        step(1'b0, 11'd56);
        chk_model();
        step(1'b1, 11'd7);
        step(1'b0, 11'd21);
        step(1'b0, 11'd49);
        step(1'b0, 11'd56);
        chk("post_rst_valid", {15'b0, dec_valid}, 16'h1);
        chk("post_rst_data", {8'b0, dec_data}, 16'd7);
        chk("post_rst_err", {12'b0, dec_err}, 16'h0);
        chk_model();

        // Randomized traffic: mostly well-formed frames, some corruption and early grants.
        for (int n = 0; n < 3000; n++) begin
            logic        g;
            logic [10:0] d;
            int          k;
            int          base;
            k = q.size();
            g = ($urandom_range(0, 9) == 0) || (k == 0 && $urandom_range(0, 2) == 0);
            if (g) begin
                d = 11'($urandom_range(0, 255));
                if ($urandom_range(0, 9) == 0) d = 11'($urandom_range(0, 2047));
            end else if (k != 0) begin
                base = int'(q[0]) % 256;
                d = (k == 1) ? 11'(base * 3) : (k == 2) ? 11'(base * 7) : 11'(base * 8);
                if ($urandom_range(0, 6) == 0) d = 11'($urandom_range(0, 2047));
            end else begin
                d = 11'($urandom_range(0, 2047));
            end
            step(g, d);
            chk_model();
        end

`ifdef MUL_SEQ_DEC_ERRCNT_EN
        // Back-to-back grants abort every cycle, driving the counter to saturation.
        for (int n = 0; n < 65540; n++) begin
            step(1'b1, 11'($urandom_range(0, 255)));
        end
        chk_model();
        chk("errcnt_sat", err_cnt, 16'hFFFF);
        step(1'b1, 11'd3);
        chk("errcnt_hold", err_cnt, 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
